// File: rtl/cmd_dispatch_fsm.sv
// cmd_dispatch_fsm: decodes host commands, starts one channel engine, waits for its done and returns a status.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   frame_valid        single-cycle command strobe, cmd_type valid with it
//   cmd_type           command code
//   frame_ready        high only while idle; accept = frame_valid & frame_ready
//   cmd_dropped        one-cycle pulse when frame_valid arrives while busy
//   ch_start           one-hot, one-cycle start pulse to the selected engine
//   ch_done            per-engine completion (pulse or level)
//   dut_en             sticky DUT enable, set/cleared by dedicated commands
//   resp_valid/ready   response handshake
//   resp_cmd           echo of the answered command
//   resp_status        0=OK, 1=TIMEOUT, 2=BAD_CMD
module cmd_dispatch_fsm #(
  parameter int NUM_CH = 4,
  parameter int CMD_W = 8,
  parameter int TO_W = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter logic [CMD_W-1:0] DUT_ON_CODE = 8'h80,
  parameter logic [CMD_W-1:0] DUT_OFF_CODE = 8'h81
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_valid,
  input  logic [CMD_W-1:0]  cmd_type,
  output logic              frame_ready,
  output logic              cmd_dropped,
  output logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  output logic              dut_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [CMD_W-1:0]  resp_cmd,
  output logic [1:0]        resp_status
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_TO = 2'd1;
  localparam logic [1:0] ST_BAD = 2'd2;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [IDX_W-1:0] idx, idx_new;
  logic [TO_W-1:0] cnt, cnt_d;
  logic [CMD_W-1:0] cmd_q;
  logic [NUM_CH-1:0] ch_start_d;
  logic [1:0] status_d;
  logic accept, is_ch, is_on, is_off, done_hit, to_hit, dut_en_d;
  assign accept = frame_valid & frame_ready;
  assign is_ch = cmd_type != '0 && cmd_type <= CMD_W'(NUM_CH);
  assign is_on = cmd_type == DUT_ON_CODE;
  assign is_off = cmd_type == DUT_OFF_CODE;
  assign idx_new = IDX_W'(cmd_type - CMD_W'(1));
  assign done_hit = ch_done[idx];
  // Counter is compared before it increments, so it never needs to wrap.
  assign to_hit = cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign resp_cmd = cmd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? (is_ch ? START : RESP) : IDLE;
      START:   state_d = WAIT;
      WAIT:    state_d = (done_hit || to_hit) ? RESP : WAIT;
      RESP:    state_d = (resp_valid && resp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Next values of the registered outputs; done beats a coincident timeout.
  always_comb begin
    ch_start_d = (accept && is_ch) ? NUM_CH'(1) << idx_new : '0;
    dut_en_d = (accept && is_on) ? 1'b1 : (accept && is_off) ? 1'b0 : dut_en;
    status_d = (accept && !is_ch) ? ((is_on || is_off) ? ST_OK : ST_BAD) :
               (state == WAIT && state_d == RESP) ? (done_hit ? ST_OK : ST_TO) : resp_status;
    cnt_d = state == WAIT ? cnt + TO_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_ready <= 1'b1;
      cmd_dropped <= 1'b0;
      ch_start <= '0;
      dut_en <= 1'b0;
      resp_valid <= 1'b0;
      resp_status <= ST_OK;
      cmd_q <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      frame_ready <= state_d == IDLE;
      cmd_dropped <= frame_valid & ~frame_ready;
      ch_start <= ch_start_d;
      dut_en <= dut_en_d;
      resp_valid <= state_d == RESP;
      resp_status <= status_d;
      cmd_q <= accept ? cmd_type : cmd_q;
      idx <= (accept && is_ch) ? idx_new : idx;
      cnt <= cnt_d;
    end
endmodule

// File: tb/tb_cmd_dispatch_fsm.sv
// tb_cmd_dispatch_fsm: directed self-checking bench for cmd_dispatch_fsm.
module tb_cmd_dispatch_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_valid = 1'b0;
  logic [7:0] cmd_type = '0;
  logic frame_ready, cmd_dropped, dut_en, resp_valid;
  logic resp_ready = 1'b0;
  logic [3:0] ch_start;
  logic [3:0] ch_done = '0;
  logic [7:0] resp_cmd;
  logic [1:0] resp_status;
  int errors = 0;
  int checks = 0;
  int drops;
  cmd_dispatch_fsm #(.NUM_CH(4), .CMD_W(8), .TO_W(16), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .cmd_type(cmd_type),
    .frame_ready(frame_ready), .cmd_dropped(cmd_dropped), .ch_start(ch_start),
    .ch_done(ch_done), .dut_en(dut_en), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_cmd(resp_cmd), .resp_status(resp_status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] c);
    frame_valid = 1'b1;
    cmd_type = c;
    tick();
    frame_valid = 1'b0;
  endtask
  task automatic ack();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask
  task automatic resp_chk(input string tag, input logic [7:0] c, input logic [1:0] s);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_cmd"}, 32'(resp_cmd), 32'(c));
    chk({tag, "_status"}, 32'(resp_status), 32'(s));
  endtask
  initial begin
    #3;
    chk("rst_ch_start", 32'(ch_start), 32'd0);
    chk("rst_dut_en", 32'(dut_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_cmd", 32'(resp_cmd), 32'd0);
    chk("rst_resp_status", 32'(resp_status), 32'd0);
    chk("rst_cmd_dropped", 32'(cmd_dropped), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rel_frame_ready", 32'(frame_ready), 32'd1);
    // channel 0, done one cycle after the start pulse
    send(8'h01);
    chk("c1_start", 32'(ch_start), 32'b0001);
    chk("c1_busy", 32'(frame_ready), 32'd0);
    chk("c1_no_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("c1_start_gone", 32'(ch_start), 32'd0);
    ch_done = 4'b0001;
    tick();
    ch_done = '0;
    resp_chk("c1", 8'h01, 2'd0);
    ack();
    chk("c1_idle_valid", 32'(resp_valid), 32'd0);
    chk("c1_idle_ready", 32'(frame_ready), 32'd1);
    // channel 2 with only foreign done bits: times out after 10 WAIT cycles
    send(8'h03);
    chk("c3_start", 32'(ch_start), 32'b0100);
    ch_done = 4'b0011;
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("c3_no_resp_yet", 32'(resp_valid), 32'd0);
    tick();
    ch_done = '0;
    resp_chk("c3", 8'h03, 2'd1);
    ack();
    // channel 3 done arrives exactly on the timeout cycle: done wins
    send(8'h04);
    chk("c4_start", 32'(ch_start), 32'b1000);
    tick();
    for (int i = 0; i < 9; i++) tick();
    ch_done = 4'b1000;
    tick();
    ch_done = '0;
    resp_chk("c4", 8'h04, 2'd0);
    ack();
    // DUT enable commands
    send(8'h80);
    chk("on_dut_en", 32'(dut_en), 32'd1);
    resp_chk("on", 8'h80, 2'd0);
    ack();
    send(8'h80);
    chk("on2_dut_en", 32'(dut_en), 32'd1);
    resp_chk("on2", 8'h80, 2'd0);
    ack();
    // bad commands leave dut_en and ch_start alone
    send(8'h00);
    chk("b00_start", 32'(ch_start), 32'd0);
    chk("b00_dut_en", 32'(dut_en), 32'd1);
    resp_chk("b00", 8'h00, 2'd2);
    ack();
    send(8'h05);
    chk("b05_start", 32'(ch_start), 32'd0);
    chk("b05_dut_en", 32'(dut_en), 32'd1);
    resp_chk("b05", 8'h05, 2'd2);
    ack();
    send(8'h7F);
    chk("b7f_start", 32'(ch_start), 32'd0);
    chk("b7f_dut_en", 32'(dut_en), 32'd1);
    resp_chk("b7f", 8'h7F, 2'd2);
    ack();
    send(8'h81);
    chk("off_dut_en", 32'(dut_en), 32'd0);
    resp_chk("off", 8'h81, 2'd0);
    ack();
    // stalled response; an ON command mid-stall must be dropped
    send(8'h05);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        frame_valid = 1'b1;
        cmd_type = 8'h80;
      end
      tick();
      frame_valid = 1'b0;
      drops += int'(cmd_dropped);
      if (i == 10) chk("stall_drop_pulse", 32'(cmd_dropped), 32'd1);
      if (i == 0 || i == 11 || i == 19) resp_chk("stall", 8'h05, 2'd2);
    end
    chk("stall_drop_count", 32'(drops), 32'd1);
    chk("stall_dut_en", 32'(dut_en), 32'd0);
    chk("stall_ready", 32'(frame_ready), 32'd0);
    ack();
    chk("stall_idle", 32'(frame_ready), 32'd1);
    tick();
    chk("stall_not_run", 32'(resp_valid), 32'd0);
    chk("stall_not_run_en", 32'(dut_en), 32'd0);
    // reset during WAIT
    send(8'h80);
    ack();
    send(8'h02);
    chk("c2_start", 32'(ch_start), 32'b0010);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_dut_en", 32'(dut_en), 32'd0);
    chk("arst_ch_start", 32'(ch_start), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_cmd", 32'(resp_cmd), 32'd0);
    chk("arst_resp_status", 32'(resp_status), 32'd0);
    chk("arst_dropped", 32'(cmd_dropped), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("arst_ready", 32'(frame_ready), 32'd1);
    ch_done = 4'b0010;
    tick();
    tick();
    ch_done = '0;
    chk("arst_no_resp", 32'(resp_valid), 32'd0);
    chk("arst_ready2", 32'(frame_ready), 32'd1);
    // reset while the start pulse is in flight
    send(8'h04);
    chk("c4b_start", 32'(ch_start), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("arst_cut_start", 32'(ch_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst2_ready", 32'(frame_ready), 32'd1);
    chk("arst2_start", 32'(ch_start), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
